// File: rtl/ctrl_pkg.sv
// Shared definitions for the decode control pipeline: instruction classes,
// data-processing opcodes, ALU command codes, condition codes and the control bundle.
package ctrl_pkg;

  localparam logic [1:0] MODE_DP  = 2'b00;
  localparam logic [1:0] MODE_MEM = 2'b01;
  localparam logic [1:0] MODE_BR  = 2'b10;
  localparam logic [1:0] MODE_RSV = 2'b11;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_EOR = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_RSB = 4'b0011;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_ADC = 4'b0101;
  localparam logic [3:0] OP_SBC = 4'b0110;
  localparam logic [3:0] OP_RSC = 4'b0111;
  localparam logic [3:0] OP_TST = 4'b1000;
  localparam logic [3:0] OP_TEQ = 4'b1001;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_CMN = 4'b1011;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] OP_BIC = 4'b1110;
  localparam logic [3:0] OP_MVN = 4'b1111;

  // ALU command codes as understood by the EXE stage (zero-extended to CMD_W there).
  localparam logic [3:0] ALU_NOP = 4'b0000;
  localparam logic [3:0] ALU_MOV = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_ADC = 4'b0011;
  localparam logic [3:0] ALU_SUB = 4'b0100;
  localparam logic [3:0] ALU_SBC = 4'b0101;
  localparam logic [3:0] ALU_AND = 4'b0110;
  localparam logic [3:0] ALU_ORR = 4'b0111;
  localparam logic [3:0] ALU_EOR = 4'b1000;
  localparam logic [3:0] ALU_MVN = 4'b1001;

  typedef enum logic [3:0] {
    COND_EQ = 4'b0000,
    COND_NE = 4'b0001,
    COND_CS = 4'b0010,
    COND_CC = 4'b0011,
    COND_MI = 4'b0100,
    COND_PL = 4'b0101,
    COND_VS = 4'b0110,
    COND_VC = 4'b0111,
    COND_HI = 4'b1000,
    COND_LS = 4'b1001,
    COND_GE = 4'b1010,
    COND_LT = 4'b1011,
    COND_GT = 4'b1100,
    COND_LE = 4'b1101,
    COND_AL = 4'b1110,
    COND_NV = 4'b1111
  } cond_e;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } state_e;

  typedef struct packed {
    logic [3:0] alu_cmd;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       branch;
    logic       s_out;
    logic       one_input;
  } ctrl_bundle_t;

  function automatic logic is_mem_op(input ctrl_bundle_t b);
    return b.mem_read | b.mem_write;
  endfunction

endpackage

// File: rtl/decode_ctrl_pipe_cond_check.sv
// ARM condition-field evaluator against NZCV; purely combinational so EXE can
// reuse it for late flag resolution.
module cond_check
  import ctrl_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);

  logic n, z, c, v;

  assign n = flags[3];
  assign z = flags[2];
  assign c = flags[1];
  assign v = flags[0];

  always_comb begin
    pass = 1'b0;
    case (cond_e'(cond))
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_CS: pass = c;
      COND_CC: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c & !z;
      COND_LS: pass = !c | z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = !z & (n == v);
      COND_LE: pass = z | (n != v);
      COND_AL: pass = 1'b1;
      COND_NV: pass = 1'b0;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/decode_ctrl_pipe.sv
// Registered decode controller: decodes ID fields into an EXE control bundle with
// one cycle of latency and holds off new issue while a memory op is outstanding.
module decode_ctrl_pipe
  import ctrl_pkg::*;
#(
  parameter int CMD_W       = 4,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             s_bit,
  input  logic [1:0]       mode,
  input  logic [3:0]       opcode,
  input  logic [3:0]       cond,
  input  logic [3:0]       flags,
  input  logic             hazard,
  input  logic             flush,
  input  logic             mem_done,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CMD_W-1:0] alu_cmd,
  output logic             mem_read,
  output logic             mem_write,
  output logic             reg_write,
  output logic             branch,
  output logic             s_out,
  output logic             one_input,
  output logic             mem_err
);

  localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  state_e       state;
  logic [CNT_W-1:0] wait_cnt;
  ctrl_bundle_t dec;
  ctrl_bundle_t issue;
  ctrl_bundle_t out_q;
  logic         cond_pass;
  logic         accept;
  logic         mem_handshake;

  cond_check u_cond_check (
    .cond  (cond),
    .flags (flags),
    .pass  (cond_pass)
  );

  // Raw decode of the instruction class and opcode, before the condition gate.
  always_comb begin
    dec = '0;
    case (mode)
      MODE_DP: begin
        case (opcode)
          OP_MOV: begin dec.alu_cmd = ALU_MOV; dec.reg_write = 1'b1; end
          OP_MVN: begin dec.alu_cmd = ALU_MVN; dec.reg_write = 1'b1; end
          OP_ADD: begin dec.alu_cmd = ALU_ADD; dec.reg_write = 1'b1; end
          OP_ADC: begin dec.alu_cmd = ALU_ADC; dec.reg_write = 1'b1; end
          OP_SUB: begin dec.alu_cmd = ALU_SUB; dec.reg_write = 1'b1; end
          OP_SBC: begin dec.alu_cmd = ALU_SBC; dec.reg_write = 1'b1; end
          OP_AND: begin dec.alu_cmd = ALU_AND; dec.reg_write = 1'b1; end
          OP_ORR: begin dec.alu_cmd = ALU_ORR; dec.reg_write = 1'b1; end
          OP_EOR: begin dec.alu_cmd = ALU_EOR; dec.reg_write = 1'b1; end
          OP_CMP: dec.alu_cmd = ALU_SUB;
          OP_TST: dec.alu_cmd = ALU_AND;
          OP_RSB, OP_RSC, OP_TEQ, OP_CMN, OP_BIC: dec.alu_cmd = ALU_NOP;
          default: dec.alu_cmd = ALU_NOP;
        endcase
      end
      MODE_MEM: begin
        dec.alu_cmd = ALU_ADD;
        if (s_bit) begin
          dec.mem_read  = 1'b1;
          dec.reg_write = 1'b1;
        end else begin
          dec.mem_write = 1'b1;
        end
      end
      MODE_BR: dec.branch = 1'b1;
      default: dec = '0;
    endcase

    // The reserved class leaves every bit clear, including one_input.
    if (mode != MODE_RSV) begin
      dec.s_out     = dec.branch ? 1'b0 : s_bit;
      dec.one_input = !((dec.alu_cmd == ALU_MOV) || (dec.alu_cmd == ALU_MVN) || dec.branch);
    end
  end

  // A failed condition still issues, but as a NOP so EXE sees a valid slot.
  always_comb begin
    issue = cond_pass ? dec : '0;
  end

  assign in_ready      = rst_n && (state == ST_RUN) && !hazard && (!out_valid || out_ready);
  assign accept        = in_valid && in_ready;
  assign mem_handshake = out_valid && out_ready && is_mem_op(out_q);

  // Output register: flush kills both the held bundle and any same-cycle transfer;
  // an emptied slot with nothing accepted becomes a bubble.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_q     <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      out_q     <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_q     <= issue;
    end else if (out_ready || !out_valid) begin
      out_valid <= 1'b0;
      out_q     <= '0;
    end
  end

  // Memory sequencer: an issued load/store parks us in MEM_WAIT until completion or
  // timeout. Flush does not touch it because the memory op is already in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_RUN;
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          wait_cnt <= '0;
          if (mem_handshake) begin
            state <= ST_MEM_WAIT;
          end
        end
        ST_MEM_WAIT: begin
          if (mem_done) begin
            state    <= ST_RUN;
            wait_cnt <= '0;
          end else if (wait_cnt == CNT_LAST) begin
            state    <= ST_RUN;
            wait_cnt <= '0;
            mem_err  <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: begin
          state    <= ST_RUN;
          wait_cnt <= '0;
        end
      endcase
    end
  end

  assign alu_cmd   = CMD_W'(out_q.alu_cmd);
  assign mem_read  = out_q.mem_read;
  assign mem_write = out_q.mem_write;
  assign reg_write = out_q.reg_write;
  assign branch    = out_q.branch;
  assign s_out     = out_q.s_out;
  assign one_input = out_q.one_input;

endmodule
